// File: rtl/synth_cfg_pkg.sv
// Shared synth configuration types and the loader's frame-protocol constants.
// Field order is MSB first, which is also the on-wire byte order of a payload.
package synth_cfg_pkg;

    localparam int unsigned N_OSCILLATORS = 2;
    localparam int unsigned ENVELOPE_LEN  = 2;
    localparam int unsigned FREQ_W        = 32;
    localparam int unsigned SHAPE_W       = 2;
    localparam int unsigned AMP_W         = 7;

    typedef enum logic [SHAPE_W-1:0] {
        SHAPE_SQUARE = 2'd0,
        SHAPE_SIN    = 2'd1,
        SHAPE_SAW    = 2'd2,
        SHAPE_TRI    = 2'd3
    } shape_e;

    typedef struct packed {
        logic [7:0] level;
        logic [7:0] rate;
    } env_stage_t;

    typedef struct packed {
        logic [FREQ_W-1:0]              freq;
        shape_e                         shape;
        logic [AMP_W-1:0]               amp;
        env_stage_t [ENVELOPE_LEN-1:0]  env;
    } wavegen_t;

    typedef struct packed {
        logic [7:0] volume;
        logic [7:0] reverb_mix;
        logic [2:0] looper_mode;
        logic [7:0] pan;
        logic [9:0] echo_delay;
    } globals_t;

    typedef struct packed {
        wavegen_t [N_OSCILLATORS-1:0] wave_gens;
        globals_t                     globals;
    } synth_t;

    typedef enum logic [7:0] {
        OPC_FULL    = 8'h01,
        OPC_WAVEGEN = 8'h02,
        OPC_GLOBALS = 8'h03
    } opcode_e;

    typedef enum logic [1:0] {
        ERR_CHECKSUM = 2'd0,
        ERR_OPCODE   = 2'd1,
        ERR_INDEX    = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_e;

    localparam int unsigned ENV_STAGE_W = $bits(env_stage_t);
    localparam int unsigned GLOBALS_W   = $bits(globals_t);
    localparam int unsigned WAVEGEN_W   = $bits(wavegen_t);
    localparam int unsigned SYNTH_W     = $bits(synth_t);

    // Widths for arbitrary oscillator/envelope counts, matching the struct layout above.
    function automatic int unsigned wavegen_w(input int unsigned env_len);
        return FREQ_W + SHAPE_W + AMP_W + env_len * ENV_STAGE_W;
    endfunction

    function automatic int unsigned synth_w(input int unsigned n_osc, input int unsigned env_len);
        return n_osc * wavegen_w(env_len) + GLOBALS_W;
    endfunction

    function automatic int unsigned payload_bytes(input int unsigned w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/frame_deser.sv
// Frame deserialiser: payload shift register, payload byte counter,
// running XOR checksum and inter-byte idle timeout.
module frame_deser #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned CNT_W          = 1,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              take,
    input  logic              start,
    input  logic              shift_en,
    input  logic              active,
    input  logic [7:0]        in_byte,
    output logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  count,
    output logic [7:0]        xor_sum,
    output logic              timeout_c
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

    logic [TO_W-1:0] idle_cnt;

    // Leading pad bits fall off the top, so the low W bits are always the value.
    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= '0;
            count   <= '0;
            xor_sum <= '0;
        end else if (take) begin
            if (start) begin
                data    <= '0;
                count   <= '0;
                xor_sum <= in_byte;
            end else begin
                xor_sum <= xor_sum ^ in_byte;
                if (shift_en) begin
                    data  <= {data[DATA_W-9:0], in_byte};
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !active || take) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end

    assign timeout_c = active && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/synth_frame_loader.sv
// Byte-stream loader: parses OPC/[IDX]/payload/CHK frames and atomically
// commits the addressed slice of the active synth configuration.
module synth_frame_loader
    import synth_cfg_pkg::*;
#(
    parameter int unsigned N_OSC          = N_OSCILLATORS,
    parameter int unsigned ENV_LEN        = ENVELOPE_LEN,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [7:0]                           in_byte,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [synth_w(N_OSC, ENV_LEN)-1:0]   synth_out,
    output logic                                 commit,
    output logic                                 err,
    output logic [1:0]                           err_code,
    output logic                                 busy
);

    localparam int unsigned WG_W      = wavegen_w(ENV_LEN);
    localparam int unsigned OUT_W     = synth_w(N_OSC, ENV_LEN);
    localparam int unsigned PB_FULL   = payload_bytes(OUT_W);
    localparam int unsigned PB_WG     = payload_bytes(WG_W);
    localparam int unsigned PB_GLB    = payload_bytes(GLOBALS_W);
    localparam int unsigned CNT_W     = $clog2(PB_FULL + 1);
    localparam int unsigned IDX_W     = (N_OSC > 1) ? $clog2(N_OSC) : 1;
    localparam int unsigned SHAPE_OFS = AMP_W + ENV_LEN * ENV_STAGE_W;

    typedef enum logic [2:0] {
        S_IDLE, S_IDX, S_PAYLOAD, S_CHECK, S_COMMIT
    } state_e;

    state_e             state, state_n;
    opcode_e            opc_q, opc_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic               commit_n, err_n;
    logic [1:0]         code_n;
    logic               take, timeout_c;
    logic [OUT_W-1:0]   data;
    logic [CNT_W-1:0]   count, pb_last;
    logic [7:0]         xor_sum;
    logic [OUT_W-1:0]   reset_val;

    // A byte landing in the timeout cycle is dropped.
    assign take = in_valid && in_ready && !timeout_c;

    frame_deser #(
        .DATA_W         (OUT_W),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_deser (
        .clk       (clk),
        .rst       (rst),
        .take      (take),
        .start     (state == S_IDLE),
        .shift_en  (state == S_PAYLOAD),
        .active    (state inside {S_IDX, S_PAYLOAD, S_CHECK}),
        .in_byte   (in_byte),
        .data      (data),
        .count     (count),
        .xor_sum   (xor_sum),
        .timeout_c (timeout_c)
    );

    always_comb begin
        reset_val = '0;
        for (int i = 0; i < int'(N_OSC); i++) begin
            reset_val[int'(GLOBALS_W) + i * int'(WG_W) + int'(SHAPE_OFS) +: SHAPE_W] = SHAPE_SIN;
        end
    end

    always_comb begin
        pb_last = CNT_W'(PB_GLB - 1);
        case (opc_q)
            OPC_FULL:    pb_last = CNT_W'(PB_FULL - 1);
            OPC_WAVEGEN: pb_last = CNT_W'(PB_WG - 1);
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            opc_q <= OPC_FULL;
            idx_q <= '0;
        end else begin
            state <= state_n;
            opc_q <= opc_n;
            idx_q <= idx_n;
        end
    end

    always_comb begin
        state_n  = state;
        opc_n    = opc_q;
        idx_n    = idx_q;
        commit_n = 1'b0;
        err_n    = 1'b0;
        code_n   = err_code;
        if (timeout_c) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
            code_n  = ERR_TIMEOUT;
        end else begin
            case (state)
                S_IDLE: if (take) begin
                    case (in_byte)
                        OPC_FULL, OPC_GLOBALS: begin
                            opc_n   = opcode_e'(in_byte);
                            state_n = S_PAYLOAD;
                        end
                        OPC_WAVEGEN: begin
                            opc_n   = OPC_WAVEGEN;
                            state_n = S_IDX;
                        end
                        default: begin
                            err_n  = 1'b1;
                            code_n = ERR_OPCODE;
                        end
                    endcase
                end
                S_IDX: if (take) begin
                    if (in_byte >= 8'(N_OSC)) begin
                        err_n   = 1'b1;
                        code_n  = ERR_INDEX;
                        state_n = S_IDLE;
                    end else begin
                        idx_n   = IDX_W'(in_byte);
                        state_n = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: if (take && count == pb_last) state_n = S_CHECK;
                S_CHECK: if (take) begin
                    if (in_byte == xor_sum) begin
                        state_n = S_COMMIT;
                    end else begin
                        err_n   = 1'b1;
                        code_n  = ERR_CHECKSUM;
                        state_n = S_IDLE;
                    end
                end
                S_COMMIT: begin
                    commit_n = 1'b1;
                    state_n  = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Only the addressed slice of synth_out is written, and only on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            synth_out <= reset_val;
            in_ready  <= 1'b1;
            commit    <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
            busy      <= 1'b0;
        end else begin
            in_ready <= (state_n != S_COMMIT);
            commit   <= commit_n;
            err      <= err_n;
            err_code <= code_n;
            busy     <= (state_n != S_IDLE);
            if (commit_n) begin
                case (opc_q)
                    OPC_FULL:    synth_out <= data;
                    OPC_WAVEGEN: synth_out[int'(GLOBALS_W) + int'(idx_q) * int'(WG_W) +: WG_W] <= data[WG_W-1:0];
                    default:     synth_out[GLOBALS_W-1:0] <= data[GLOBALS_W-1:0];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_synth_frame_loader.sv
// Directed bench for synth_frame_loader: frame vector table plus hand-written
// sequences for latency, back-to-back frames, timeout and mid-frame reset.
module tb_synth_frame_loader;
    import synth_cfg_pkg::*;

    localparam int unsigned PAY_W = 184;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         in_byte;
    logic               in_valid;
    logic               in_ready;
    logic [SYNTH_W-1:0] synth_out;
    logic               commit;
    logic               err;
    logic [1:0]         err_code;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    int commit_cnt = 0;
    int err_cnt = 0;

    synth_t          exp_s, before_s, after_s;
    logic [7:0]      frame_q[$];
    logic [7:0]      bb_q[$];
    logic [PAY_W-1:0] pay_q;

    typedef struct {
        logic [7:0] opc;
        logic [7:0] idx;
        logic [7:0] fill;
        logic [7:0] flip;
        logic       exp_commit;
        logic [1:0] exp_code;
    } vec_t;
    vec_t vecs[10];

    synth_frame_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .synth_out (synth_out),
        .commit    (commit),
        .err       (err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (commit) commit_cnt <= commit_cnt + 1;
        if (err)    err_cnt    <= err_cnt + 1;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic synth_t reset_synth();
        synth_t s;
        s = '0;
        for (int i = 0; i < int'(N_OSCILLATORS); i++) s.wave_gens[i].shape = SHAPE_SIN;
        return s;
    endfunction

    // Called just after a clock edge; returns just after the handshake edge.
    task automatic send_byte(input logic [7:0] b);
        logic r;
        int   guard;
        guard    = 0;
        in_byte  = b;
        in_valid = 1'b1;
        forever begin
            r = in_ready;
            @(posedge clk); #1;
            if (r) break;
            stall_cnt++;
            guard++;
            if (guard > 8) begin
                checks++;
                errors++;
                $display("FAIL send_byte: in_ready low for %0d cycles, need 1", guard);
                break;
            end
        end
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) send_byte(frame_q[i]);
        in_valid = 1'b0;
    endtask

    // Payload byte k = fill + k; CHK is the true XOR with flip applied.
    task automatic build_frame(input logic [7:0] opc, input logic [7:0] idx,
                               input logic [7:0] fill, input logic [7:0] flip);
        int         pb;
        logic [7:0] x;
        logic [7:0] b;
        frame_q.delete();
        pay_q = '0;
        frame_q.push_back(opc);
        pb = (opc == 8'h01) ? 23 : (opc == 8'h02) ? 10 : (opc == 8'h03) ? 5 : 0;
        if (pb == 0) return;
        if (opc == 8'h02) begin
            frame_q.push_back(idx);
            if (idx >= 8'd2) return;
        end
        for (int k = 0; k < pb; k++) begin
            b = fill + 8'(k);
            frame_q.push_back(b);
            pay_q = {pay_q[PAY_W-9:0], b};
        end
        x = 8'h00;
        foreach (frame_q[i]) x = x ^ frame_q[i];
        frame_q.push_back(x ^ flip);
    endtask

    task automatic apply_model(input logic [7:0] opc, input logic [7:0] idx);
        case (opc)
            8'h01:   exp_s = synth_t'(pay_q[SYNTH_W-1:0]);
            8'h02:   exp_s.wave_gens[int'(idx)] = wavegen_t'(pay_q[WAVEGEN_W-1:0]);
            default: exp_s.globals = globals_t'(pay_q[GLOBALS_W-1:0]);
        endcase
    endtask

    // Entered just after the last byte's handshake edge.
    task automatic expect_outcome(input string name, input logic exp_commit, input logic [1:0] exp_code);
        logic       seen_c, seen_e;
        logic [1:0] code;
        int         at;
        seen_c = 1'b0; seen_e = 1'b0; code = 2'd0; at = -1;
        for (int c = 0; c < 4; c++) begin
            if ((commit || err) && at < 0) begin
                at = c; seen_c = commit; seen_e = err; code = err_code;
            end
            @(posedge clk); #1;
        end
        check({name, " outcome"}, 256'({seen_c, seen_e}), exp_commit ? 256'(2'b10) : 256'(2'b01));
        check({name, " latency"}, 256'(at), exp_commit ? 256'(1) : 256'(0));
        if (!exp_commit) check({name, " err_code"}, 256'(code), 256'(exp_code));
        check({name, " synth_out"}, 256'(synth_out), 256'(exp_s));
        check({name, " busy"}, 256'(busy), 256'(0));
    endtask

    initial begin
        logic [PAY_W-1:0] a5;
        logic [79:0]      p80;
        logic [7:0]       x;
        wavegen_t         w;
        int               n, c0, e0;

        vecs[0] = '{8'h03, 8'h00, 8'h10, 8'h00, 1'b1, 2'd0};
        vecs[1] = '{8'h02, 8'h00, 8'h20, 8'h00, 1'b1, 2'd0};
        vecs[2] = '{8'h03, 8'h00, 8'h30, 8'h01, 1'b0, 2'd0};
        vecs[3] = '{8'h07, 8'h00, 8'h00, 8'h00, 1'b0, 2'd1};
        vecs[4] = '{8'h02, 8'h02, 8'h00, 8'h00, 1'b0, 2'd2};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd1};
        vecs[6] = '{8'h01, 8'h00, 8'h33, 8'h00, 1'b1, 2'd0};
        vecs[7] = '{8'h02, 8'hFF, 8'h00, 8'h00, 1'b0, 2'd2};
        vecs[8] = '{8'h02, 8'h01, 8'h40, 8'h00, 1'b1, 2'd0};
        vecs[9] = '{8'h01, 8'h00, 8'h50, 8'h80, 1'b0, 2'd0};

        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        exp_s = reset_synth();
        check("rst synth_out", 256'(synth_out), 256'(exp_s));
        check("rst in_ready", 256'(in_ready), 256'(1));
        check("rst commit", 256'(commit), 256'(0));
        check("rst err", 256'(err), 256'(0));
        check("rst err_code", 256'(err_code), 256'(0));
        check("rst busy", 256'(busy), 256'(0));

        // Full frame, every payload byte 0xA5; CHK = 0x01 ^ 0xA5 (odd count) = 0xA4.
        frame_q.delete();
        frame_q.push_back(8'h01);
        for (int k = 0; k < 23; k++) frame_q.push_back(8'hA5);
        frame_q.push_back(8'hA4);
        send_frame();
        check("full pre-commit", 256'(commit), 256'(0));
        check("full commit-cycle in_ready", 256'(in_ready), 256'(0));
        check("full not early", 256'(synth_out), 256'(exp_s));
        @(posedge clk); #1;
        a5 = {23{8'hA5}};
        check("full commit", 256'(commit), 256'(1));
        check("full err", 256'(err), 256'(0));
        check("full synth_out", 256'(synth_out), 256'(a5[SYNTH_W-1:0]));
        exp_s = synth_t'(a5[SYNTH_W-1:0]);
        @(posedge clk); #1;
        check("full commit pulse", 256'(commit), 256'(0));
        check("full in_ready back", 256'(in_ready), 256'(1));

        // Single oscillator update at index 1.
        w.freq = 32'h00001000; w.shape = SHAPE_SAW; w.amp = 7'h11;
        w.env[1] = '{8'h22, 8'h33}; w.env[0] = '{8'h44, 8'h55};
        p80 = {7'b0, w};
        before_s = synth_t'(synth_out);
        frame_q.delete();
        frame_q.push_back(8'h02);
        frame_q.push_back(8'h01);
        for (int k = 0; k < 10; k++) frame_q.push_back(p80[79 - 8 * k -: 8]);
        x = 8'h00;
        foreach (frame_q[i]) x = x ^ frame_q[i];
        frame_q.push_back(x);
        send_frame();
        exp_s.wave_gens[1] = w;
        expect_outcome("wg1", 1'b1, 2'd0);
        after_s = synth_t'(synth_out);
        check("wg1 slot1", 256'(after_s.wave_gens[1]), 256'(w));
        check("wg1 slot0 kept", 256'(after_s.wave_gens[0]), 256'(before_s.wave_gens[0]));
        check("wg1 globals kept", 256'(after_s.globals), 256'(before_s.globals));

        for (int v = 0; v < 10; v++) begin
            build_frame(vecs[v].opc, vecs[v].idx, vecs[v].fill, vecs[v].flip);
            send_frame();
            if (vecs[v].exp_commit) apply_model(vecs[v].opc, vecs[v].idx);
            expect_outcome($sformatf("vec%0d", v), vecs[v].exp_commit, vecs[v].exp_code);
        end

        // Two globals frames with in_valid never dropped.
        build_frame(8'h03, 8'h00, 8'h70, 8'h00);
        bb_q = frame_q;
        build_frame(8'h03, 8'h00, 8'h80, 8'h00);
        foreach (frame_q[i]) bb_q.push_back(frame_q[i]);
        frame_q = bb_q;
        apply_model(8'h03, 8'h00);
        stall_cnt = 0; c0 = commit_cnt; e0 = err_cnt;
        send_frame();
        repeat (3) begin @(posedge clk); #1; end
        check("b2b stall cycles", 256'(stall_cnt), 256'(1));
        check("b2b commits", 256'(commit_cnt - c0), 256'(2));
        check("b2b errs", 256'(err_cnt - e0), 256'(0));
        check("b2b synth_out", 256'(synth_out), 256'(exp_s));

        // Stall mid-payload until the idle timeout fires.
        send_byte(8'h01);
        for (int k = 0; k < 5; k++) send_byte(8'hA5);
        in_valid = 1'b0;
        check("to busy", 256'(busy), 256'(1));
        n = 0;
        while (!err && n < 70000) begin
            @(posedge clk); #1;
            n++;
        end
        check("to cycles", 256'(n), 256'(65536));
        check("to err_code", 256'(err_code), 256'(3));
        check("to busy low", 256'(busy), 256'(0));
        check("to synth_out", 256'(synth_out), 256'(exp_s));
        @(posedge clk); #1;
        check("to err pulse", 256'(err), 256'(0));

        build_frame(8'h03, 8'h00, 8'h90, 8'h00);
        send_frame();
        apply_model(8'h03, 8'h00);
        expect_outcome("post-to", 1'b1, 2'd0);

        // Reset in the middle of a frame.
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_s = reset_synth();
        check("midrst synth_out", 256'(synth_out), 256'(exp_s));
        check("midrst busy", 256'(busy), 256'(0));
        check("midrst in_ready", 256'(in_ready), 256'(1));
        check("midrst err_code", 256'(err_code), 256'(0));

        build_frame(8'h03, 8'h00, 8'h60, 8'h00);
        send_frame();
        apply_model(8'h03, 8'h00);
        expect_outcome("post-rst", 1'b1, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
